// File: rtl/systolic_tile_ctrl.sv
// systolic_tile_ctrl
// Sequencing controller for a weight-stationary UNIT_NUM x UNIT_NUM systolic
// tile. For each tile of a job it loads UNIT_NUM^2 weight beats, one PE at a
// time. It then streams cfg_a_rows activation beats and waits for the array
// pipeline to drain before reporting the tile complete.
//
// Ports
//   s_clk, s_rst        clock, synchronous active-high reset
//   start               one-cycle job request, honoured only while idle
//   cfg_tile_num        tiles per job (0 behaves as 1), latched at start
//   cfg_a_rows          activation beats per tile (0 behaves as 1), latched
//   MtrxB_slice_valid   weight beat offered
//   MtrxB_slice_ready   controller accepts a weight beat (weight load phase)
//   MtrxA_slice_valid   activation beat offered
//   MtrxA_slice_ready   controller accepts an activation beat (feed phase)
//   weight_we           one-hot PE weight write strobe, only on a B handshake
//   a_feed_en           array advances one activation beat (A handshake)
//   psum_capture        a_feed_en delayed by DRAIN_CYC cycles
//   tile_done           one-cycle pulse per completed tile
//   busy                high from the cycle after an accepted start until done
//   done                one-cycle pulse alongside the last tile_done
module systolic_tile_ctrl #(
  parameter int UNIT_NUM  = 8,
  parameter int DRAIN_CYC = 2 * UNIT_NUM - 1
) (
  input  logic                           s_clk,
  input  logic                           s_rst,
  input  logic                           start,
  input  logic [7:0]                     cfg_tile_num,
  input  logic [15:0]                    cfg_a_rows,
  input  logic                           MtrxB_slice_valid,
  output logic                           MtrxB_slice_ready,
  input  logic                           MtrxA_slice_valid,
  output logic                           MtrxA_slice_ready,
  output logic [UNIT_NUM*UNIT_NUM-1:0]   weight_we,
  output logic                           a_feed_en,
  output logic                           psum_capture,
  output logic                           tile_done,
  output logic                           busy,
  output logic                           done
);

  localparam int W_NUM   = UNIT_NUM * UNIT_NUM;
  localparam int W_IDX_W = (W_NUM > 1) ? $clog2(W_NUM) : 1;
  localparam int DRN_W   = $clog2(DRAIN_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_FEED_A,
    S_DRAIN,
    S_NEXT
  } state_t;

  state_t               state;
  logic [W_IDX_W-1:0]   w_idx;
  logic [15:0]          a_cnt;
  logic [15:0]          a_last;     // index of the final A beat of a tile
  logic [7:0]           tile_cnt;
  logic [7:0]           tile_last;  // index of the final tile of the job
  logic [DRN_W-1:0]     drain_cnt;
  logic [DRAIN_CYC-1:0] cap_sr;
  logic                 b_hs;
  logic                 a_hs;

  // Readies come from the registered state alone, so no valid->ready path.
  assign MtrxB_slice_ready = (state == S_LOAD_W);
  assign MtrxA_slice_ready = (state == S_FEED_A);

  assign b_hs = MtrxB_slice_valid & MtrxB_slice_ready;
  assign a_hs = MtrxA_slice_valid & MtrxA_slice_ready;

  assign weight_we    = b_hs ? (W_NUM'(1) << w_idx) : '0;
  assign a_feed_en    = a_hs;
  assign psum_capture = cap_sr[DRAIN_CYC-1];

  // NOTE: state and counters use non-blocking assignments so every branch
  // below sees the pre-edge values, whatever order the statements appear in.
  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      state     <= S_IDLE;
      w_idx     <= '0;
      a_cnt     <= '0;
      a_last    <= '0;
      tile_cnt  <= '0;
      tile_last <= '0;
      drain_cnt <= '0;
      cap_sr    <= '0;
      tile_done <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      // The capture delay line runs in every state so the beats still in
      // flight keep emerging during the drain.
      cap_sr    <= (cap_sr << 1) | DRAIN_CYC'(a_feed_en);
      tile_done <= 1'b0;
      done      <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            a_last    <= (cfg_a_rows == 16'd0) ? 16'd0 : cfg_a_rows - 16'd1;
            tile_last <= (cfg_tile_num == 8'd0) ? 8'd0 : cfg_tile_num - 8'd1;
            w_idx     <= '0;
            a_cnt     <= '0;
            tile_cnt  <= '0;
            drain_cnt <= '0;
            busy      <= 1'b1;
            state     <= S_LOAD_W;
          end
        end

        S_LOAD_W: begin
          if (b_hs) begin
            // The index returns to zero on the final beat rather than
            // incrementing past it, so it never wraps.
            if (w_idx == W_IDX_W'(W_NUM - 1)) begin
              w_idx <= '0;
              state <= S_FEED_A;
            end else begin
              w_idx <= w_idx + W_IDX_W'(1);
            end
          end
        end

        S_FEED_A: begin
          if (a_hs) begin
            if (a_cnt == a_last) begin
              drain_cnt <= '0;
              state     <= S_DRAIN;
            end else begin
              a_cnt <= a_cnt + 16'd1;
            end
          end
        end

        S_DRAIN: begin
          // DRAIN_CYC full cycles follow the last A beat, so its capture
          // lands in the final drain cycle, just before tile_done.
          if (drain_cnt == DRN_W'(DRAIN_CYC - 1)) begin
            tile_done <= 1'b1;
            done      <= (tile_cnt == tile_last);
            state     <= S_NEXT;
          end else begin
            drain_cnt <= drain_cnt + DRN_W'(1);
          end
        end

        S_NEXT: begin
          if (tile_cnt == tile_last) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            tile_cnt <= tile_cnt + 8'd1;
            w_idx    <= '0;
            a_cnt    <= '0;
            state    <= S_LOAD_W;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
